pc_fetch: RTL and testbench
===========================

PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  downstream cannot accept an instruction; freeze fetch.
REQ-005 br_taken  input  1  redirect request; selects br_target over pc+4.
REQ-006 br_target  input  32  redirect address.
REQ-007 imem_req  output  1  instruction-memory read request.
REQ-008 imem_addr  output  32  read address, equal to current pc.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle; meaningful only while imem_req=1.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 inst_valid  output  1  inst/inst_pc hold a valid fetched instruction.
REQ-012 inst  output  32  fetched instruction, registered.
REQ-013 inst_pc  output  32  address inst was fetched from, registered.
REQ-014 misalign  output  1  misaligned redirect flag (only with MISALIGN_TRAP_EN).

Function
REQ-015 States SHALL be IDLE, FETCH, HOLD; encoding is free.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to FETCH unconditionally.
REQ-017 In FETCH with stall=0, imem_req SHALL be 1 and imem_addr SHALL equal pc; imem_req SHALL be 0 in IDLE, HOLD, and FETCH with stall=1.
REQ-018 In FETCH with imem_req=1 and imem_ack=1 (no redirect): inst<=imem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4.
REQ-019 After the ack cycle the state SHALL be HOLD if stall=1 on the next cycle, else inst_valid SHALL be a one-cycle pulse and FETCH continues.
REQ-020 Back-to-back acks SHALL yield one instruction per cycle (throughput 1, latency 1 cycle ack-to-inst_valid).
REQ-021 In HOLD, inst, inst_pc, inst_valid SHALL be held unchanged while stall=1; when stall=0, inst_valid<=0 and state->FETCH.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 br_taken=1 in any non-IDLE cycle SHALL set pc<=br_target, inst_valid<=0, state->FETCH, overriding stall and any same-cycle imem_ack (that rdata discarded).
REQ-024 br_taken in IDLE SHALL be ignored.
REQ-025 imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL immediately (no clock) force state=IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc=0, misalign=0.
REQ-027 Reset asserted mid-fetch SHALL abort the transaction; a later ack is ignored until FETCH is re-entered.

Configuration
REQ-028 Macro MISALIGN_TRAP_EN: when defined, a redirect with br_target[1:0]!=0 SHALL set misalign<=1 (sticky until reset), leave pc unchanged, and stop in HOLD with inst_valid=0 and imem_req=0.
REQ-029 Without MISALIGN_TRAP_EN, misalign SHALL be tied 0 and br_target SHALL be loaded with bits [1:0] forced to 00.

Verification
REQ-030 Reset release, imem_ack=1 every cycle, rdata=pc -> imem_addr 0,4,8,...; inst_valid continuous from cycle 2, inst_pc=inst.
REQ-031 Ack at pc=0x10 with stall=1 for 3 cycles -> inst/inst_pc=0x10 held 3 cycles, imem_req=0; fetch resumes at 0x14.
REQ-032 br_taken=1, br_target=0x100 same cycle as ack at pc=0x20 -> no inst_valid for 0x20, next imem_addr=0x100.
REQ-033 RESET_PC=32'hFFFF_FFFC, ack each cycle -> addresses 0xFFFF_FFFC then 0x0000_0000.
REQ-034 rst_n dropped mid-FETCH at pc=0x40 -> outputs at reset values without a clock edge; restart at RESET_PC.
REQ-035 br_target=0x102: with MISALIGN_TRAP_EN -> misalign=1, imem_req stays 0; without -> imem_addr=0x100.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: program-counter and instruction-fetch front end.
// Holds the PC and issues one instruction-memory read per cycle while in FETCH.
// It registers the returned word with its address. It also handles downstream
// stalls, which hold the last instruction, and branch redirects.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall                 downstream busy; freezes fetch
//   br_taken, br_target   redirect request and target address
//   imem_req, imem_addr   memory read request (FETCH and not stalled), address = pc
//   imem_ack, imem_rdata  memory response, qualified by imem_req
//   inst_valid, inst, inst_pc  registered fetched instruction and its address
//   misalign              sticky misaligned-redirect flag
//
// Build option: define MISALIGN_TRAP_EN to trap on redirects whose target is
// not word aligned. In the default build, the low target bits are cleared and
// misalign is tied low.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            valid_q, valid_d;
  logic            mis_q, mis_d;
  logic            br_bad;
  logic [XLEN-1:0] br_addr;

  // The request depends on the live stall input, so it cannot wait a cycle.
  assign imem_req   = (state_q == S_FETCH) && !stall;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign br_addr    = {br_target[XLEN-1:2], 2'b00};

`ifdef MISALIGN_TRAP_EN
  assign br_bad   = (br_target[1:0] != 2'b00);
  assign misalign = mis_q;
`else
  logic unused_br_lsb;
  assign unused_br_lsb = ^{br_target[1:0], mis_q};
  assign br_bad        = 1'b0;
  assign misalign      = 1'b0;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    mis_d     = mis_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_HOLD: begin
        if (mis_q) begin
          // A trapped fetch stays parked until reset.
          state_d = S_HOLD;
          valid_d = 1'b0;
        end else if (br_taken) begin
          // A redirect beats stall and discards any same-cycle response.
          valid_d = 1'b0;
          if (br_bad) begin
            mis_d   = 1'b1;
            state_d = S_HOLD;
          end else begin
            pc_d    = br_addr;
            state_d = S_FETCH;
          end
        end else if (state_q == S_FETCH) begin
          if (stall) begin
            if (valid_q) state_d = S_HOLD;
          end else if (imem_ack) begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + XLEN'(4);
          end else begin
            valid_d = 1'b0;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch. The bench pushes each accepted fetch into a
// scoreboard queue and checks the queue against the registered instruction
// one cycle later.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n, stall, br_taken, imem_ack;
  logic [31:0] br_target, imem_rdata;

  logic        req, valid, mis;
  logic [31:0] addr, inst, inst_pc;
  logic        w_req, w_valid, w_mis;
  logic [31:0] w_addr, w_inst, w_inst_pc;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_req(req), .imem_addr(addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(valid),
    .inst(inst), .inst_pc(inst_pc), .misalign(mis)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(w_valid),
    .inst(w_inst), .inst_pc(w_inst_pc), .misalign(w_mis)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic a, input logic [31:0] d);
    @(negedge clk);
    stall = s; br_taken = b; br_target = t; imem_ack = a; imem_rdata = d;
    #1;
  endtask

  task automatic pop_chk();
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_empty: observed empty queue expected entry");
    end else begin
      e = exp_q.pop_front();
      chk("sb_valid", 32'(valid), 32'd1);
      chk("sb_inst", inst, e);
      chk("sb_inst_pc", inst_pc, e);
    end
  endtask

  // One acknowledged fetch at exp_pc with rdata equal to the address.
  task automatic fetch_one();
    drive(1'b0, 1'b0, 32'h0, 1'b1, exp_pc);
    chk("fetch_req", 32'(req), 32'd1);
    chk("fetch_addr", addr, exp_pc);
    exp_q.push_back(exp_pc);
    edge_wait();
    pop_chk();
    exp_pc = exp_pc + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    #12;
    chk("rst_addr", addr, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_wrap_mis", 32'(w_mis), 32'd0);
    chk("rst_wrap_valid", 32'(w_valid), 32'd0);
    chk("rst_wrap_inst", w_inst ^ w_inst_pc, 32'h0);
    chk("rst_wrap_req", 32'(w_req), 32'd0);

    // IDLE cycle: ack and redirect are both ignored.
    @(negedge clk);
    rst_n = 1'b1; br_taken = 1'b1; br_target = 32'h200;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("idle_req", 32'(req), 32'd0);
    edge_wait();
    chk("idle_ack_ignored", 32'(valid), 32'd0);
    chk("idle_br_ignored", addr, 32'h0);

    // Streaming fetch; the wrap instance crosses 0xFFFF_FFFC -> 0.
    exp_pc = 32'h0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1, exp_pc);
      chk("stream_req", 32'(req), 32'd1);
      chk("stream_addr", addr, exp_pc);
      chk("wrap_addr", w_addr, 32'hFFFF_FFFC + 32'(i * 4));
      exp_q.push_back(exp_pc);
      edge_wait();
      pop_chk();
      exp_pc = exp_pc + 32'd4;
    end

    // Ack at 0x10, then stall for three cycles.
    fetch_one();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD0_BAD0);
      chk("stall_req", 32'(req), 32'd0);
      edge_wait();
      chk("stall_inst", inst, 32'h10);
      chk("stall_inst_pc", inst_pc, 32'h10);
      chk("stall_valid", 32'(valid), 32'd1);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("hold_exit_req", 32'(req), 32'd0);
    edge_wait();
    chk("hold_exit_valid", 32'(valid), 32'd0);
    fetch_one();
    fetch_one();
    fetch_one();

    // Redirect in the same cycle as the ack at 0x20.
    drive(1'b0, 1'b1, 32'h100, 1'b1, 32'h20);
    chk("br_ack_req", 32'(req), 32'd1);
    chk("br_ack_addr", addr, 32'h20);
    edge_wait();
    chk("br_ack_valid", 32'(valid), 32'd0);
    chk("br_ack_target", addr, 32'h100);
    exp_pc = 32'h100;
    fetch_one();

    // A redirect overrides stall.
    drive(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    chk("br_stall_req", 32'(req), 32'd0);
    edge_wait();
    chk("br_stall_addr", addr, 32'h40);
    chk("br_stall_valid", 32'(valid), 32'd0);

    // Asynchronous reset mid-fetch at 0x40.
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("pre_rst_req", 32'(req), 32'd1);
    chk("pre_rst_addr", addr, 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req", 32'(req), 32'd0);
    chk("async_rst_addr", addr, 32'h0);
    chk("async_rst_valid", 32'(valid), 32'd0);
    chk("async_rst_inst", inst, 32'h0);
    chk("async_rst_inst_pc", inst_pc, 32'h0);
    chk("async_rst_mis", 32'(mis), 32'd0);
    imem_ack = 1'b1;
    edge_wait();
    chk("rst_ack_ignored", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD1_BAD1;
    #1;
    chk("restart_idle_req", 32'(req), 32'd0);
    edge_wait();
    chk("restart_idle_valid", 32'(valid), 32'd0);
    exp_pc = 32'h0;
    fetch_one();

    // Misaligned redirect target.
    drive(1'b0, 1'b1, 32'h102, 1'b0, 32'h0);
    edge_wait();
`ifdef MISALIGN_TRAP_EN
    chk("mis_flag", 32'(mis), 32'd1);
    chk("mis_req", 32'(req), 32'd0);
    chk("mis_valid", 32'(valid), 32'd0);
    chk("mis_pc_kept", addr, 32'h4);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("mis_req_stuck", 32'(req), 32'd0);
    edge_wait();
    chk("mis_sticky", 32'(mis), 32'd1);
    chk("mis_valid_stuck", 32'(valid), 32'd0);
`else
    chk("mis_tied", 32'(mis), 32'd0);
    chk("mis_aligned_addr", addr, 32'h100);
    chk("mis_valid", 32'(valid), 32'd0);
    exp_pc = 32'h100;
    fetch_one();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
